// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - oversampled UART receiver, majority vote, valid/ready output; define UART_RX_PARITY_EN to add a parity bit
module uart_rx_framed #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLING = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rx,
    input  logic                 ready_in,
    output logic                 valid_out,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int H     = OVERSAMPLING / 2;
    localparam int CNT_W = $clog2(OVERSAMPLING);
    localparam int BIT_W = $clog2(DATA_BITS);

    // Reject illegal frame formats at elaboration time.
    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        OVERSAMPLING < 8 || (OVERSAMPLING % 2) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_framed: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rxs;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 s_a;
    logic                 s_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc;
    logic                 sample_tick;
    logic                 vote;
    logic                 last_data;
    logic                 last_stop;
    logic                 frame_done;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    assign busy = (state != IDLE);

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; decisions happen at cnt = H+1 using the two stored samples plus the live one.
    always_comb begin
        state_next  = state;
        frame_done  = 1'b0;
        sample_tick = (state != IDLE) && (cnt == CNT_W'(H + 1));
        vote        = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
        last_data   = (bit_cnt == BIT_W'(DATA_BITS - 1));
        last_stop   = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample_tick) begin
                    state_next = vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_tick && last_data) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY: begin
                if (sample_tick) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample_tick && last_stop) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sample counter, vote samples, bit shifting and per-frame error accumulation.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            s_a      <= 1'b1;
            s_b      <= 1'b1;
            shreg    <= '0;
            ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            if (state_next == IDLE) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(OVERSAMPLING - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state != IDLE && cnt == CNT_W'(H - 1)) begin
                s_a <= rxs;
            end
            if (state != IDLE && cnt == CNT_W'(H)) begin
                s_b <= rxs;
            end

            if (state == IDLE && !rxs) begin
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                ferr_acc <= 1'b0;
            end

            if (sample_tick) begin
                case (state)
                    DATA: begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: par_bit <= vote;
`endif
                    STOP: begin
                        stop_cnt <= 1'b1;
                        if (!vote) begin
                            ferr_acc <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output register: load on completion when free or being drained, otherwise drop and flag overrun.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!valid_out || ready_in) begin
                    valid_out <= 1'b1;
                    data_out  <= shreg;
                    frame_err <= ferr_acc | ~vote;
`ifdef UART_RX_PARITY_EN
                    parity_err <= (^shreg) ^ par_bit ^ PARITY_ODD[0];
`else
                    parity_err <= 1'b0;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - directed self-checking bench for uart_rx_framed
module tb_uart_rx_framed;

    localparam int OS = 16;
    localparam int H  = OS / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int N8  = 1 + 8 + (PAR ? 1 : 0) + 1;
    localparam int LAT = H + 4 + (N8 - 1) * OS;

    logic       clk;
    logic       n_rst;
    logic       rx;
    logic       ready_in;
    logic       valid_out;
    logic [7:0] data_out;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int n_checks;
    int n_pass;

    uart_rx_framed dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .rx         (rx),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

`ifdef UART_RX_PARITY_EN
    logic       ready_p;
    logic       valid_p;
    logic [6:0] data_p;
    logic       ferr_p;
    logic       perr_p;
    logic       ovr_p;
    logic       busy_p;

    uart_rx_framed #(.DATA_BITS(7), .STOP_BITS(2), .OVERSAMPLING(OS), .PARITY_ODD(0)) dut_p (
        .clk        (clk),
        .n_rst      (n_rst),
        .rx         (rx),
        .ready_in   (ready_p),
        .valid_out  (valid_p),
        .data_out   (data_p),
        .frame_err  (ferr_p),
        .parity_err (perr_p),
        .overrun    (ovr_p),
        .busy       (busy_p)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        step(OS);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nd, input bit with_par,
                              input logic pbit, input int ns, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < nd; i++) drive_bit(d[i]);
        if (with_par) drive_bit(pbit);
        for (int i = 0; i < ns; i++) drive_bit(stop_v);
        rx = 1'b1;
    endtask

    task automatic send8(input logic [7:0] d, input logic stop_v);
        send_frame({1'b0, d}, 8, PAR, ^d, 1, stop_v);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_rst    = 1'b0;
        rx       = 1'b1;
        ready_in = 1'b0;
`ifdef UART_RX_PARITY_EN
        ready_p  = 1'b0;
`endif
        step(3);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);
        n_rst = 1'b1;
        step(5);

        // 0xA5 with exact completion latency, then hold and drain
        fork
            send8(8'hA5, 1'b1);
            begin
                step(LAT - 1);
                chk("a5_valid_before", valid_out, 0);
                chk("a5_busy_before", busy, 1);
                step(1);
                chk("a5_valid_at", valid_out, 1);
                chk("a5_busy_after", busy, 0);
            end
        join
        step(30);
        chk("a5_hold_valid", valid_out, 1);
        chk("a5_data", data_out, 8'hA5);
        chk("a5_ferr", frame_err, 0);
        chk("a5_perr", parity_err, 0);
        ready_in = 1'b1;
        step(1);
        ready_in = 1'b0;
        chk("a5_drained", valid_out, 0);
        chk("a5_data_kept", data_out, 8'hA5);

        // 4-cycle glitch: busy pulse, start bit rejected
        rx = 1'b0;
        step(2);
        chk("gl_busy_e2", busy, 0);
        step(1);
        chk("gl_busy_e3", busy, 1);
        step(1);
        rx = 1'b1;
        step(7);
        chk("gl_busy_e11", busy, 1);
        step(1);
        chk("gl_busy_e12", busy, 0);
        step(40);
        chk("gl_no_valid", valid_out, 0);

        // back-to-back 0x11, 0x22 without draining: overrun pulse
        send8(8'h11, 1'b1);
        chk("b2b_first", data_out, 8'h11);
        fork
            send8(8'h22, 1'b1);
            begin
                step(LAT - 1);
                chk("ovr_before", overrun, 0);
                step(1);
                chk("ovr_pulse", overrun, 1);
                step(1);
                chk("ovr_after", overrun, 0);
            end
        join
        chk("ovr_data_held", data_out, 8'h11);
        chk("ovr_valid_held", valid_out, 1);

        // same, but handshake on the completion edge: word replaced, no overrun
        fork
            send8(8'h22, 1'b1);
            begin
                step(LAT - 1);
                ready_in = 1'b1;
                step(1);
                ready_in = 1'b0;
                chk("hs_no_ovr", overrun, 0);
                chk("hs_valid", valid_out, 1);
                chk("hs_data", data_out, 8'h22);
            end
        join
        ready_in = 1'b1;
        step(1);
        ready_in = 1'b0;
        chk("hs_drained", valid_out, 0);
        step(20);

        // 0x3C with a zero stop bit
        send8(8'h3C, 1'b0);
        chk("fe_valid", valid_out, 1);
        chk("fe_data", data_out, 8'h3C);
        chk("fe_flag", frame_err, 1);
        step(40);

        // reset mid-frame while a word is held
        rx = 1'b0;
        step(40);
        n_rst = 1'b0;
        rx    = 1'b1;
        step(1);
        n_rst = 1'b1;
        chk("mr_valid", valid_out, 0);
        chk("mr_data", data_out, 0);
        chk("mr_ferr", frame_err, 0);
        chk("mr_ovr", overrun, 0);
        chk("mr_busy", busy, 0);
        step(40);
        chk("mr_idle", busy, 0);
        send8(8'h5A, 1'b1);
        chk("5a_valid", valid_out, 1);
        chk("5a_data", data_out, 8'h5A);
        chk("5a_ferr", frame_err, 0);
        chk("5a_perr", parity_err, 0);

`ifdef UART_RX_PARITY_EN
        // 7E2: 0x07 has three ones, so parity bit 0 is wrong and 1 is right
        n_rst = 1'b0;
        step(1);
        n_rst = 1'b1;
        step(5);
        send_frame(9'h007, 7, 1'b1, 1'b0, 2, 1'b1);
        chk("p0_valid", valid_p, 1);
        chk("p0_data", data_p, 7'h07);
        chk("p0_perr", perr_p, 1);
        chk("p0_ferr", ferr_p, 0);
        ready_p = 1'b1;
        step(1);
        ready_p = 1'b0;
        step(20);
        send_frame(9'h007, 7, 1'b1, 1'b1, 2, 1'b1);
        chk("p1_valid", valid_p, 1);
        chk("p1_perr", perr_p, 0);
        chk("p1_ferr", ferr_p, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
